// File: rtl/snickerbits_pkg.sv
// Shared types and limits for the snickerbits nonce generator.
package snickerbits_pkg;

  localparam int MAX_LANES = 16;
  localparam int MAX_WIDTH = 64;

  typedef enum logic {
    GEN_IDLE = 1'b0,
    GEN_RUN  = 1'b1
  } gen_state_e;

endpackage

// File: rtl/snickerbits_nonce_lane.sv
// One nonce lane: strided offset register, exhaustion test and nonce adder.
// The offset is one bit wider than the nonce so a full 2^WIDTH range plus
// the final stride never overflows.
module snickerbits_nonce_lane
  import snickerbits_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int WIDTH     = 32
) (
  input  logic             clk_axi,
  input  logic             rst,
  input  logic             run,
  input  logic             load,
  input  logic [WIDTH:0]   lane_index,
  input  logic [WIDTH-1:0] span,
  input  logic [WIDTH-1:0] base,
  input  logic             fire,
  output logic             exhausted,
  output logic             valid,
  output logic [WIDTH-1:0] nonce
);

  localparam int OW = WIDTH + 1;
  localparam logic [WIDTH:0] STRIDE = OW'(NUM_LANES);

  logic [WIDTH:0] off;

  // Offset restarts at the lane index on load and advances by the lane count per transfer.
  always_ff @(posedge clk_axi) begin
    if (!rst) begin
      off <= '0;
    end else if (load) begin
      off <= lane_index;
    end else if (fire) begin
      off <= off + STRIDE;
    end
  end

  assign exhausted = off > {1'b0, span};
  assign valid     = run & ~exhausted;
  // Nonce wraps naturally through all-ones; forced to zero outside RUN.
  assign nonce     = run ? (base + off[WIDTH-1:0]) : '0;

endmodule

// File: rtl/snickerbits_nonce_gen.sv
// Multi-lane nonce generator: job FSM, latched range, epoch tracking and
// NUM_LANES independent valid/ready nonce lanes.
module snickerbits_nonce_gen
  import snickerbits_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int WIDTH     = 32,
  parameter int EPOCH_W   = 16
) (
  input  logic                       clk_axi,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [WIDTH-1:0]           base,
  input  logic [WIDTH-1:0]           last,
  input  logic                       wrap_en,
  output logic [NUM_LANES-1:0]       nonce_valid,
  input  logic [NUM_LANES-1:0]       nonce_ready,
  output logic [NUM_LANES*WIDTH-1:0] nonce,
  output logic                       busy,
  output logic                       done,
  output logic                       wrapped,
  output logic [EPOCH_W-1:0]         epoch
);

  localparam int OW = WIDTH + 1;

  gen_state_e state, state_nxt;

  logic [WIDTH-1:0]     base_q;
  logic [WIDTH-1:0]     span_q;
  logic                 wrap_en_q;
  logic [EPOCH_W-1:0]   epoch_q;
  logic                 done_q;
  logic                 wrapped_q;

  logic                 run;
  logic                 accept;
  logic                 reload;
  logic                 done_nxt;
  logic                 wrapped_nxt;
  logic                 all_exh;
  logic [NUM_LANES-1:0] exh;
  logic [NUM_LANES-1:0] vld;

  assign run     = (state == GEN_RUN);
  assign all_exh = &exh;

  // Next-state decode: start accepted only in IDLE, abort wins over exhaustion in RUN.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    reload      = 1'b0;
    done_nxt    = 1'b0;
    wrapped_nxt = 1'b0;
    case (state)
      GEN_IDLE: begin
        if (start && !abort) begin
          state_nxt = GEN_RUN;
          accept    = 1'b1;
        end
      end
      GEN_RUN: begin
        if (abort) begin
          state_nxt = GEN_IDLE;
        end else if (all_exh) begin
          if (wrap_en_q) begin
            reload      = 1'b1;
            wrapped_nxt = 1'b1;
          end else begin
            state_nxt = GEN_IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = GEN_IDLE;
    endcase
  end

  // State register and control flags; done/wrapped are single-cycle pulses.
  always_ff @(posedge clk_axi) begin
    if (!rst) begin
      state     <= GEN_IDLE;
      wrap_en_q <= 1'b0;
      epoch_q   <= '0;
      done_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      done_q    <= done_nxt;
      wrapped_q <= wrapped_nxt;
      if (accept) begin
        wrap_en_q <= wrap_en;
        epoch_q   <= '0;
      end else if (reload) begin
        epoch_q   <= epoch_q + 1'b1;
      end
    end
  end

  // Job range latch; only read while in RUN, so it needs no reset.
  always_ff @(posedge clk_axi) begin
    if (accept) begin
      base_q <= base;
      span_q <= last - base;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    snickerbits_nonce_lane #(
      .NUM_LANES (NUM_LANES),
      .WIDTH     (WIDTH)
    ) u_lane (
      .clk_axi    (clk_axi),
      .rst        (rst),
      .run        (run),
      .load       (accept | reload),
      .lane_index (OW'(g)),
      .span       (span_q),
      .base       (base_q),
      .fire       (vld[g] & nonce_ready[g]),
      .exhausted  (exh[g]),
      .valid      (vld[g]),
      .nonce      (nonce[g*WIDTH +: WIDTH])
    );
  end

  assign nonce_valid = vld;
  assign busy        = run;
  assign done        = done_q;
  assign wrapped     = wrapped_q;
  assign epoch       = epoch_q;

endmodule

// File: tb/tb_snickerbits_nonce_gen.sv
// Scoreboard bench for snickerbits_nonce_gen (4 lanes, 8-bit nonces).
module tb_snickerbits_nonce_gen;

  localparam int NL = 4;
  localparam int W  = 8;
  localparam int EW = 16;

  logic              clk_axi = 1'b0;
  logic              rst     = 1'b0;
  logic              start   = 1'b0;
  logic              abort   = 1'b0;
  logic              wrap_en = 1'b0;
  logic [W-1:0]      base    = '0;
  logic [W-1:0]      last    = '0;
  logic [NL-1:0]     nonce_ready = '1;
  logic [NL-1:0]     nonce_valid;
  logic [NL*W-1:0]   nonce;
  logic              busy;
  logic              done;
  logic              wrapped;
  logic [EW-1:0]     epoch;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int xfers = 0;
  int job_x0 = 0;
  int last_xfer_cyc = 0;
  int last_valid_cyc = 0;
  int done_cnt = 0;
  int wrap_cnt = 0;

  logic [W-1:0] exp_q [NL][$];
  bit           prev_hold [NL];
  logic [W-1:0] prev_nonce [NL];

  snickerbits_nonce_gen #(
    .NUM_LANES (NL),
    .WIDTH     (W),
    .EPOCH_W   (EW)
  ) dut (
    .clk_axi     (clk_axi),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .base        (base),
    .last        (last),
    .wrap_en     (wrap_en),
    .nonce_valid (nonce_valid),
    .nonce_ready (nonce_ready),
    .nonce       (nonce),
    .busy        (busy),
    .done        (done),
    .wrapped     (wrapped),
    .epoch       (epoch)
  );

  always #5 clk_axi = ~clk_axi;

  always @(posedge clk_axi) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_axi);
    #1;
  endtask

  // Expected per-lane nonce sequence for one pass over [b, l].
  task automatic push_job(input logic [W-1:0] b, input logic [W-1:0] l);
    logic [W-1:0] d;
    int span;
    d = l - b;
    span = int'(d);
    for (int ln = 0; ln < NL; ln++)
      for (int off = ln; off <= span; off += NL)
        exp_q[ln].push_back(W'(int'(b) + off));
  endtask

  task automatic start_job(input logic [W-1:0] b, input logic [W-1:0] l,
                           input logic w, input int passes);
    for (int p = 0; p < passes; p++) push_job(b, l);
    job_x0  = xfers;
    base    = b;
    last    = l;
    wrap_en = w;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic finish_job(input int exp_x);
    int n = 0;
    while (!done && n < 3000) begin
      step();
      n++;
    end
    check("done_seen", done, 1);
    check("done_latency", cyc - last_xfer_cyc, 2);
    check("valid_gap", last_valid_cyc, last_xfer_cyc);
    check("busy_at_done", busy, 0);
    check("xfer_count", xfers - job_x0, exp_x);
    step();
    check("done_once", done, 0);
    for (int i = 0; i < NL; i++) check($sformatf("leftover_l%0d", i), exp_q[i].size(), 0);
  endtask

  task automatic wait_wrap();
    int n = 0;
    while (!wrapped && n < 100) begin
      step();
      n++;
    end
    check("wrap_seen", wrapped, 1);
  endtask

  // Transfer monitor: pops the scoreboard and checks that held nonces stay put.
  always @(negedge clk_axi) begin
    if (!rst) begin
      for (int i = 0; i < NL; i++) prev_hold[i] = 1'b0;
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (prev_hold[i]) begin
          check($sformatf("hold_valid_l%0d", i), nonce_valid[i], 1);
          check($sformatf("hold_nonce_l%0d", i), nonce[i*W +: W], prev_nonce[i]);
        end
        if (nonce_valid[i] && nonce_ready[i]) begin
          xfers++;
          last_xfer_cyc = cyc;
          if (exp_q[i].size() == 0)
            check($sformatf("extra_xfer_l%0d", i), nonce[i*W +: W], 'hDEAD);
          else
            check($sformatf("nonce_l%0d", i), nonce[i*W +: W], exp_q[i].pop_front());
        end
        prev_hold[i]  = !abort && nonce_valid[i] && !nonce_ready[i];
        prev_nonce[i] = nonce[i*W +: W];
      end
      if (|nonce_valid) last_valid_cyc = cyc;
      if (done) done_cnt++;
      if (wrapped) wrap_cnt++;
    end
  end

  initial begin
    int d0;

    // Reset state
    repeat (2) step();
    check("rst_valid", nonce_valid, 0);
    check("rst_nonce", nonce, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wrapped", wrapped, 0);
    check("rst_epoch", epoch, 0);
    rst = 1'b1;
    step();

    // Two full beats
    start_job(8'h10, 8'h17, 1'b0, 1);
    check("first_valid", nonce_valid, 4'hF);
    check("first_nonce", nonce, 32'h13121110);
    check("first_busy", busy, 1);
    finish_job(8);

    // Uneven range: lanes 2/3 issue once
    start_job(8'h10, 8'h15, 1'b0, 1);
    finish_job(6);

    // Range through all-ones, then the full 256-value range
    start_job(8'hFE, 8'h01, 1'b0, 1);
    finish_job(4);
    start_job(8'h00, 8'hFF, 1'b0, 1);
    finish_job(256);

    // Single-nonce job
    start_job(8'h42, 8'h42, 1'b0, 1);
    finish_job(1);

    // Backpressure on lane 2
    start_job(8'h10, 8'h17, 1'b0, 1);
    nonce_ready = 4'b1011;
    repeat (5) step();
    check("bp_valid2", nonce_valid[2], 1);
    check("bp_nonce2", nonce[23:16], 8'h12);
    nonce_ready = 4'hF;
    finish_job(8);

    // Start while busy leaves the range alone
    nonce_ready = 4'h0;
    start_job(8'h10, 8'h17, 1'b0, 1);
    base  = 8'h80;
    last  = 8'hFF;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("busy_start_nonce", nonce, 32'h13121110);
    nonce_ready = 4'hF;
    finish_job(8);

    // Start with abort in IDLE is ignored
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", busy, 0);
    check("sa_valid", nonce_valid, 0);
    step();
    check("sa_busy2", busy, 0);

    // Continuous mode, then abort
    start_job(8'h00, 8'h03, 1'b1, 2);
    wait_wrap();
    check("wrap1_epoch", epoch, 1);
    check("wrap1_valid", nonce_valid, 4'hF);
    check("wrap1_nonce", nonce, 32'h03020100);
    check("wrap1_busy", busy, 1);
    step();
    check("wrap_once", wrapped, 0);
    wait_wrap();
    check("wrap2_epoch", epoch, 2);
    nonce_ready = 4'h0;
    d0 = done_cnt;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", nonce_valid, 0);
    check("abort_nonce", nonce, 0);
    check("abort_epoch", epoch, 2);
    repeat (3) step();
    check("abort_no_done", done_cnt, d0);
    check("wrap_total", wrap_cnt, 2);
    for (int i = 0; i < NL; i++) check($sformatf("wrap_left_l%0d", i), exp_q[i].size(), 0);
    nonce_ready = 4'hF;

    // Reset in the middle of a continuous job
    start_job(8'h00, 8'h03, 1'b1, 2);
    wait_wrap();
    check("pre_rst_epoch", epoch, 1);
    nonce_ready = 4'h0;
    rst = 1'b0;
    step();
    check("mid_rst_valid", nonce_valid, 0);
    check("mid_rst_nonce", nonce, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_wrapped", wrapped, 0);
    check("mid_rst_epoch", epoch, 0);
    rst = 1'b1;
    for (int i = 0; i < NL; i++) exp_q[i].delete();
    nonce_ready = 4'hF;
    step();
    check("post_rst_busy", busy, 0);

    // Recovery after reset
    start_job(8'h20, 8'h23, 1'b0, 1);
    finish_job(4);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/snickerbits_nonce_gen.md
Name: snickerbits_nonce_gen

Overview:
- Parametrised multi-lane nonce generator that feeds NUM_LANES SHA-256 miner cores in the snickerbits design.
- Generalises the single fixed-increment accumulator to several things:
  - configurable width and lane count;
  - an inclusive [base, last] range that may wrap modulo 2^WIDTH;
  - a per-lane valid/ready handshake;
  - an optional continuous (re-epoch) mode.
- Sits between the AXI-side job registers and the hash cores.

Parameters:
NUM_LANES, 4, number of independent nonce output lanes (1..16)
WIDTH, 32, nonce width in bits (8..64)
EPOCH_W, 16, width of the epoch counter

Ports:
clk_axi  input  1  sole clock
rst  input  1  synchronous reset, active-low
start  input  1  job start request; sampled only in IDLE
abort  input  1  cancel the current job
base  input  WIDTH  first nonce of the range; latched on accepted start
last  input  WIDTH  last nonce of the range (inclusive); latched on accepted start
wrap_en  input  1  continuous mode; latched on accepted start
nonce_valid  output  NUM_LANES  per-lane nonce valid
nonce_ready  input  NUM_LANES  per-lane consumer ready
nonce  output  NUM_LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH]
busy  output  1  high while in RUN
done  output  1  one-cycle pulse at normal job completion
wrapped  output  1  one-cycle pulse at each epoch restart
epoch  output  EPOCH_W  number of completed epochs in the current job; wraps modulo 2^EPOCH_W

Behaviour:
- Reset (rst low at a clk_axi edge): state IDLE; all outputs 0 (nonce_valid, nonce, busy, done, wrapped, epoch). Reset has priority over everything, including mid-RUN; no done pulse is produced.
- States:
  - IDLE. start=1 and abort=0 -> RUN. On that edge:
    - latch base, last and wrap_en;
    - span = last - base, modulo 2^WIDTH;
    - set lane i offset off_i = i, held in a WIDTH+1-bit register;
    - clear epoch.
    - start=1 with abort=1 in IDLE: start is ignored.
  - RUN:
    - busy=1.
    - Lane i is exhausted when off_i > span.
    - nonce_valid[i] = !exhausted_i.
    - nonce_i = (base + off_i[WIDTH-1:0]) modulo 2^WIDTH. The range therefore passes through all-ones to zero naturally.
- Latency: valids rise in the first cycle after the edge that accepted start.
- Handshake:
  - A transfer occurs on lane i when nonce_valid[i] and nonce_ready[i] are both high at an edge; then off_i += NUM_LANES.
  - Once valid is asserted, valid and nonce stay stable until transferred. Lanes are independent, and any subset may transfer in the same cycle.
- All lanes exhausted (all_exh, combinational from the offset registers) in RUN, at the next edge:
  - wrap_en=0: go to IDLE, done=1 for one cycle, busy=0.
  - wrap_en=1: stay in RUN, reload off_i = i, wrapped=1 for one cycle, epoch += 1.
  - Resulting timing: final transfer at the edge ending cycle T; all valids low in cycle T+1; done or wrapped high in cycle T+2. After a wrap, valids are high again in T+2.
- abort=1 in RUN: at the next edge go to IDLE, drop all valids, no done or wrapped pulse. epoch holds its last value until the next start.
- start in RUN is ignored; the latched range is unaffected.
- Full range (base == last + 1, modulo 2^WIDTH) gives span = 2^WIDTH - 1, i.e. exactly 2^WIDTH nonces. The WIDTH+1-bit offset prevents overflow; a single-nonce job (base == last) is legal.
- nonce is a don't-care while its valid is low, but it is driven to 0 in IDLE.

Decomposition:
- Shared package snickerbits_pkg:
  - enum gen_state_e {GEN_IDLE, GEN_RUN};
  - localparam limits MAX_LANES=16 and MAX_WIDTH=64.
- One sub-module, snickerbits_nonce_lane, instantiated NUM_LANES times via generate:
  - holds the offset register, exhausted/valid logic and the nonce adder;
  - inputs: load, lane_index, span, base, fire.
- The top level holds the FSM, the latched job registers, all_exh reduction, and the done/wrapped/epoch logic.

Test Plan (NUM_LANES=4, WIDTH=8):
- base=0x10, last=0x17, wrap_en=0, all ready=1 -> beat 1: nonces 0x10,0x11,0x12,0x13; beat 2: 0x14..0x17; one cycle with valids low; then done pulses once; busy falls with done; 8 transfers total.
- base=0x10, last=0x15 -> lanes 0 and 1 issue {0x10,0x14} and {0x11,0x15}; lanes 2 and 3 issue only 0x12 and 0x13; done after 6 transfers.
- base=0xFE, last=0x01 -> single beat 0xFE,0xFF,0x00,0x01; done; base=0x00, last=0xFF -> exactly 256 unique nonces, then done.
- Backpressure: base=0x10, last=0x17, nonce_ready[2]=0 for 5 cycles -> lane 2 holds 0x12 stable with valid high; other lanes finish; done only two cycles after lane 2 delivers 0x16.
- wrap_en=1, base=0x00, last=0x03 -> after the beat 0..3, wrapped pulses, epoch=1, lanes reissue 0..3; after the second beat epoch=2; abort then returns to IDLE with no done pulse.
- Edge cases:
  - rst low mid-RUN -> all outputs 0 the next cycle;
  - start while busy -> range unchanged;
  - start and abort together in IDLE -> stays IDLE.
